// File: rtl/shift_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : shift_seq_pkg
// Brief    : Shared types and op encodings for the shift sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shift_seq_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [7:0] amt_t;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
//------------------------------------------------------------------------------
// Module   : shift_step
// Brief    : One combinational shift/rotate step of k bits (0..STEP) with carry.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0]           value,
    input  logic [1:0]                 op,
    input  logic [$clog2(STEP+1)-1:0]  k,
    output logic [WIDTH-1:0]           shifted,
    output logic                       carry
);

    // One guard bit on each side captures the last bit shifted out.
    logic [WIDTH:0]        w_lsl;
    logic [WIDTH:0]        w_lsr;
    logic signed [WIDTH:0] w_asr;
    logic [WIDTH-1:0]      w_ror;

    assign w_lsl = {1'b0, value} << k;
    assign w_lsr = {value, 1'b0} >> k;
    assign w_asr = $signed({value, 1'b0}) >>> k;
    assign w_ror = (value >> k) | (value << (WIDTH - int'(k)));

    always_comb begin
        shifted = w_ror;
        carry   = w_ror[WIDTH-1];
        case (op)
            SH_LSL: begin
                shifted = w_lsl[WIDTH-1:0];
                carry   = w_lsl[WIDTH];
            end
            SH_LSR: begin
                shifted = w_lsr[WIDTH:1];
                carry   = w_lsr[0];
            end
            SH_ASR: begin
                shifted = w_asr[WIDTH:1];
                carry   = w_asr[0];
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
//------------------------------------------------------------------------------
// Module   : shift_sequencer
// Brief    : Two-port round-robin multi-cycle ARM barrel shifter (STEP bits/cycle).
//            SHIFT_SEQ_RRX_EN enables RRX for immediate ROR #0.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [3:0]           req_op,
    input  logic [1:0]           req_imm,
    input  logic [15:0]          req_amt,
    input  logic [2*WIDTH-1:0]   req_data,
    input  logic [1:0]           req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_cout
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int KW = $clog2(STEP + 1);
    localparam logic [CW-1:0] STEP_C = CW'(STEP);

    state_t           r_state;
    logic             r_ptr;
    logic [WIDTH-1:0] r_val;
    logic             r_cout;
    logic [1:0]       r_op;
    logic             r_id;
    logic [CW-1:0]    r_rem;
`ifdef SHIFT_SEQ_RRX_EN
    logic             r_rrx;
    logic             r_cin;
    logic             w_rrx;
`endif

    logic             w_grant;
    logic             w_accept;
    logic [1:0]       w_op;
    logic             w_imm;
    amt_t             w_amt;
    int               w_amt_i;
    logic [WIDTH-1:0] w_data;
    logic             w_cin;
    logic [CW-1:0]    w_n;
    logic             w_cout0;
    logic [KW-1:0]    w_k;
    logic [WIDTH-1:0] w_shifted;
    logic             w_carry;
    logic [WIDTH-1:0] w_val_nxt;
    logic             w_cout_nxt;

    // Pointer has priority; an idle pointer requester cedes the grant.
    assign w_grant = req_valid[r_ptr] ? r_ptr : ~r_ptr;

    always_comb begin
        req_ready = 2'b00;
        if (rst_n && (r_state == IDLE)) begin
            req_ready[w_grant] = req_valid[w_grant];
        end
    end

    assign w_accept = |req_ready;
    assign w_op     = w_grant ? req_op[3:2]               : req_op[1:0];
    assign w_imm    = w_grant ? req_imm[1]                : req_imm[0];
    assign w_amt    = w_grant ? req_amt[15:8]             : req_amt[7:0];
    assign w_data   = w_grant ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    assign w_cin    = w_grant ? req_cin[1]                : req_cin[0];
    assign w_amt_i  = int'(w_amt);

    always_comb begin
        w_n     = '0;
        w_cout0 = w_cin;
`ifdef SHIFT_SEQ_RRX_EN
        w_rrx   = 1'b0;
`endif
        if (w_imm && (w_amt == '0)) begin
            case (w_op)
                SH_LSR, SH_ASR: w_n = CW'(WIDTH);
`ifdef SHIFT_SEQ_RRX_EN
                SH_ROR: begin
                    w_rrx = 1'b1;
                    w_n   = CW'(1);
                end
`endif
                default: ;
            endcase
        end else if (w_amt != '0) begin
            case (w_op)
                SH_LSL, SH_LSR: w_n = (w_amt_i > WIDTH + 1) ? CW'(WIDTH + 1) : CW'(w_amt_i);
                SH_ASR:         w_n = (w_amt_i > WIDTH) ? CW'(WIDTH) : CW'(w_amt_i);
                default: begin
                    w_n = CW'(w_amt_i % WIDTH);
                    // Nonzero rotate by a multiple of WIDTH leaves data but reports its MSB.
                    if ((w_amt_i % WIDTH) == 0) begin
                        w_cout0 = w_data[WIDTH-1];
                    end
                end
            endcase
        end
    end

    assign w_k = (r_rem > STEP_C) ? KW'(STEP) : KW'(r_rem);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .value   (r_val),
        .op      (r_op),
        .k       (w_k),
        .shifted (w_shifted),
        .carry   (w_carry)
    );

    always_comb begin
        w_val_nxt  = w_shifted;
        w_cout_nxt = w_carry;
`ifdef SHIFT_SEQ_RRX_EN
        if (r_rrx) begin
            w_val_nxt  = {r_cin, r_val[WIDTH-1:1]};
            w_cout_nxt = r_val[0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 1'b0;
            r_val   <= '0;
            r_cout  <= 1'b0;
            r_op    <= SH_LSL;
            r_id    <= 1'b0;
            r_rem   <= '0;
`ifdef SHIFT_SEQ_RRX_EN
            r_rrx   <= 1'b0;
            r_cin   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_val   <= w_data;
                        r_cout  <= w_cout0;
                        r_op    <= w_op;
                        r_id    <= w_grant;
                        r_rem   <= w_n;
                        r_ptr   <= ~w_grant;
`ifdef SHIFT_SEQ_RRX_EN
                        r_rrx   <= w_rrx;
                        r_cin   <= w_cin;
`endif
                        r_state <= (w_n == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    r_val <= w_val_nxt;
                    r_cout <= w_cout_nxt;
                    r_rem <= r_rem - CW'(w_k);
                    if (r_rem == CW'(w_k)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == DONE);
    assign rsp_id    = rsp_valid ? r_id   : 1'b0;
    assign rsp_data  = rsp_valid ? r_val  : '0;
    assign rsp_cout  = rsp_valid ? r_cout : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_shift_sequencer
// Brief    : Randomized self-checking bench for shift_sequencer (honours SHIFT_SEQ_RRX_EN).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [3:0]           req_op;
    logic [1:0]           req_imm;
    logic [15:0]          req_amt;
    logic [2*WIDTH-1:0]   req_data;
    logic [1:0]           req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [WIDTH-1:0]     rsp_data;
    logic                 rsp_cout;

    shift_sequencer #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_imm   (req_imm),
        .req_amt   (req_amt),
        .req_data  (req_data),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        imm;
        logic [7:0]  amt;
        logic [31:0] data;
        logic        cin;
    } rq_t;

    rq_t pend [2];
    bit  act  [2];
    bit  ptr;
    int  n_total = 0;
    int  n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic rq_t mk(input logic [1:0] op, input logic imm, input logic [7:0] amt,
                               input logic [31:0] data, input logic cin);
        rq_t r;
        r.op = op; r.imm = imm; r.amt = amt; r.data = data; r.cin = cin;
        return r;
    endfunction

    function automatic rq_t rnd_req();
        rq_t r;
        r.op   = 2'($urandom_range(0, 3));
        r.imm  = 1'($urandom_range(0, 1));
        r.data = $urandom;
        r.cin  = 1'($urandom_range(0, 1));
        if (r.imm) begin
            r.amt = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 31));
        end else begin
            case ($urandom_range(0, 5))
                0:       r.amt = 8'd0;
                1:       r.amt = 8'd32;
                2:       r.amt = 8'd33;
                3:       r.amt = 8'($urandom_range(34, 255));
                4:       r.amt = 8'd64;
                default: r.amt = 8'($urandom_range(1, 31));
            endcase
        end
        return r;
    endfunction

    // Whole-count reference: effective count from the ARM rules, then one-shot shift.
    function automatic void model(input rq_t r, output logic [31:0] res, output logic c,
                                  output int cyc);
        int a, n;
        bit rrx;
        logic [31:0] t;
        a = int'(r.amt); n = 0; rrx = 0;
        res = r.data; c = r.cin;
        if (r.imm && a == 0) begin
            if (r.op == SH_LSR || r.op == SH_ASR) n = 32;
`ifdef SHIFT_SEQ_RRX_EN
            if (r.op == SH_ROR) rrx = 1;
`endif
        end else if (a != 0) begin
            if (r.op == SH_LSL || r.op == SH_LSR) n = (a > 33) ? 33 : a;
            else if (r.op == SH_ASR)              n = (a > 32) ? 32 : a;
            else begin
                n = a % 32;
                if (n == 0) c = r.data[31];
            end
        end
        cyc = (n + STEP - 1) / STEP;
        if (rrx) begin
            res = {r.cin, r.data[31:1]};
            c   = r.data[0];
            cyc = 1;
        end else if (n > 0) begin
            case (r.op)
                SH_LSL: begin
                    res = (n >= 32) ? 32'd0 : (r.data << n);
                    t = r.data >> (32 - n);
                    c = (n > 32) ? 1'b0 : t[0];
                end
                SH_LSR: begin
                    res = (n >= 32) ? 32'd0 : (r.data >> n);
                    t = r.data >> (n - 1);
                    c = (n > 32) ? 1'b0 : t[0];
                end
                SH_ASR: begin
                    res = (n >= 32) ? {32{r.data[31]}} : 32'($signed(r.data) >>> n);
                    t = r.data >> (n - 1);
                    c = t[0];
                end
                default: begin
                    res = (r.data >> n) | (r.data << (32 - n));
                    c = res[31];
                end
            endcase
        end
    endfunction

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            req_valid[p]            = act[p];
            req_op[2*p +: 2]        = pend[p].op;
            req_imm[p]              = pend[p].imm;
            req_amt[8*p +: 8]       = pend[p].amt;
            req_data[32*p +: 32]    = pend[p].data;
            req_cin[p]              = pend[p].cin;
        end
    endtask

    // Entered and left at a falling edge; serves the next expected grant end to end.
    task automatic run_one(input int hold);
        logic [1:0]  exp_rdy;
        bit          g;
        logic [31:0] er;
        logic        ec;
        int          cyc, lat, w;
        g = act[ptr] ? ptr : !ptr;
        drive();
        #1;
        w = 0;
        while (req_ready == 2'b00 && w < 4) begin
            @(negedge clk); #1; w++;
        end
        exp_rdy = 2'b00;
        exp_rdy[g] = 1'b1;
        chk("grant", 64'(req_ready), 64'(exp_rdy));
        model(pend[g], er, ec, cyc);
        ptr = !g;
        @(negedge clk);
        act[g] = 0;
        drive();
        lat = 1;
        while (!rsp_valid && lat < 24) begin
            @(negedge clk); lat++;
        end
        chk("latency", 64'(lat), 64'(1 + cyc));
        chk("rsp_id", 64'(rsp_id), 64'(g));
        chk("rsp_data", 64'(rsp_data), 64'(er));
        chk("rsp_cout", 64'(rsp_cout), 64'(ec));
        chk("done_ready", 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold", 64'({rsp_valid, rsp_id, rsp_cout, rsp_data}), 64'({1'b1, g, ec, er}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        ptr = 0;
        pend[0] = rnd_req(); pend[1] = rnd_req();
        act[0] = 1; act[1] = 1;
        drive();
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_id, rsp_cout, rsp_data}), 64'd0);
        act[0] = 0; act[1] = 0;
        drive();
        rst_n = 1'b1;
        @(negedge clk);

        pend[0] = mk(SH_LSL, 1'b1, 8'd4, 32'h0000_00F1, 1'b0); act[0] = 1;
        run_one(0);
        pend[1] = mk(SH_LSR, 1'b1, 8'd0, 32'h8000_0001, 1'b0); act[1] = 1;
        run_one(1);
        pend[0] = mk(SH_ASR, 1'b0, 8'd200, 32'h8000_0000, 1'b0); act[0] = 1;
        run_one(0);
        pend[1] = mk(SH_ROR, 1'b0, 8'd32, 32'h8000_0000, 1'b0); act[1] = 1;
        run_one(0);
        pend[0] = mk(SH_ROR, 1'b1, 8'd0, 32'h0000_0003, 1'b1); act[0] = 1;
        run_one(0);
        pend[0] = mk(SH_LSL, 1'b0, 8'd33, 32'hFFFF_FFFF, 1'b1); act[0] = 1;
        run_one(0);

        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && $urandom_range(0, 1) == 1) begin
                    pend[p] = rnd_req(); act[p] = 1;
                end
            end
            if (!act[0] && !act[1]) begin
                pend[it % 2] = rnd_req(); act[it % 2] = 1;
            end
            run_one(int'($urandom_range(0, 2)));
        end
        while (act[0] || act[1]) run_one(0);

        // Abort a long shift with reset, then check the pair restarts from requester 0.
        pend[0] = mk(SH_LSR, 1'b0, 8'd33, 32'hDEAD_BEEF, 1'b1);
        pend[1] = mk(SH_ASR, 1'b0, 8'd40, 32'h8123_4567, 1'b0);
        act[0] = 1; act[1] = 1;
        drive();
        #1;
        chk("pre_rst_grant", 64'(|req_ready), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr = 0;
        run_one(3);
        run_one(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
